// File: rtl/alu_sequencer_if.sv
// Request/ALU/response bundle between a requester, the ALU sequencer and its ALU.
// slave  : the sequencer side (accepts requests, drives ALU operands, returns responses)
// master : the requester/ALU side
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        funct7b0;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alucontrol;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_taken;
  logic        rsp_illegal;

  modport slave (
    input  req_valid, opcode, funct3, funct7b5, funct7b0, rs1_val, rs2_val, imm,
    output req_ready,
    output alu_a, alu_b, alucontrol,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_taken, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req_valid, opcode, funct3, funct7b5, funct7b0, rs1_val, rs2_val, imm,
    input  req_ready,
    input  alu_a, alu_b, alucontrol,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_taken, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: decodes one RISC-V ALU/branch/lui request, presents registered
// operands to an external ALU for one EXEC cycle, captures result and flags and
// holds them as a response until the consumer accepts it.
// Flow: IDLE (ready) -> EXEC (ALU works) -> DONE (response valid) -> IDLE.
module alu_sequencer (
  input logic           clk,
  input logic           reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_PASSB = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_MUL   = 4'b1010;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_accept;

  logic [3:0]  w_dec_ctrl;
  logic [31:0] w_dec_a;
  logic [31:0] w_dec_b;
  logic        w_dec_illegal;
  logic        w_dec_branch;

  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alucontrol;
  logic        r_illegal;
  logic        r_is_branch;
  logic [2:0]  r_funct3;

  logic [31:0] r_rsp_result;
  logic [3:0]  r_rsp_flags;
  logic        r_rsp_taken;
  logic        r_rsp_illegal;
  logic        w_cond;

  assign w_accept        = bus.req_valid && (r_state == IDLE);
  assign bus.req_ready   = (r_state == IDLE);
  assign bus.rsp_valid   = (r_state == DONE);
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alucontrol  = r_alucontrol;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_flags   = r_rsp_flags;
  assign bus.rsp_taken   = r_rsp_taken;
  assign bus.rsp_illegal = r_rsp_illegal;

  // Decode the request fields into ALU operation, operands and illegal/branch class.
  always_comb begin
    w_dec_ctrl    = ALU_ADD;
    w_dec_a       = bus.rs1_val;
    w_dec_b       = bus.rs2_val;
    w_dec_illegal = 1'b0;
    w_dec_branch  = 1'b0;
    case (bus.opcode)
      OP_R: begin
        case (bus.funct3)
          3'b000:  w_dec_ctrl = bus.funct7b0 ? ALU_MUL : (bus.funct7b5 ? ALU_SUB : ALU_ADD);
          3'b111:  w_dec_ctrl = ALU_AND;
          3'b110:  w_dec_ctrl = ALU_OR;
          3'b100:  w_dec_ctrl = ALU_XOR;
          3'b001:  w_dec_ctrl = ALU_SLL;
          3'b101:  w_dec_ctrl = bus.funct7b5 ? ALU_SRA : ALU_SRL;
          default: w_dec_illegal = 1'b1;
        endcase
        // mul shares only funct3=000; any other funct3 with the M bit is unsupported
        w_dec_illegal = w_dec_illegal | (bus.funct7b0 && (bus.funct3 != 3'b000));
      end
      OP_I: begin
        w_dec_b = bus.imm;
        case (bus.funct3)
          3'b000:  w_dec_ctrl = ALU_ADD;
          3'b111:  w_dec_ctrl = ALU_AND;
          3'b110:  w_dec_ctrl = ALU_OR;
          3'b100:  w_dec_ctrl = ALU_XOR;
          3'b001:  w_dec_ctrl = ALU_SLL;
          3'b101:  w_dec_ctrl = bus.funct7b5 ? ALU_SRA : ALU_SRL;
          default: w_dec_illegal = 1'b1;
        endcase
      end
      OP_B: begin
        w_dec_ctrl    = ALU_SUB;
        w_dec_branch  = 1'b1;
        w_dec_illegal = (bus.funct3 == 3'b010) || (bus.funct3 == 3'b011);
      end
      OP_LUI: begin
        w_dec_ctrl = ALU_PASSB;
        w_dec_a    = 32'd0;
        w_dec_b    = bus.imm;
      end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // Evaluate the branch condition from the ALU flags {v,c,n,z} of the subtraction.
  always_comb begin
    w_cond = 1'b0;
    case (r_funct3)
      3'b000:  w_cond = bus.alu_flags[0];
      3'b001:  w_cond = ~bus.alu_flags[0];
      3'b100:  w_cond = bus.alu_flags[1] ^ bus.alu_flags[3];
      3'b101:  w_cond = ~(bus.alu_flags[1] ^ bus.alu_flags[3]);
      3'b110:  w_cond = ~bus.alu_flags[2];
      3'b111:  w_cond = bus.alu_flags[2];
      default: w_cond = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: EXEC is always a single cycle, DONE waits for the consumer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_accept ? EXEC : IDLE;
      EXEC:    w_state_next = DONE;
      DONE:    w_state_next = bus.rsp_ready ? IDLE : DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // Register decoded operation on acceptance and capture the ALU outcome at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_a       <= 32'd0;
      r_alu_b       <= 32'd0;
      r_alucontrol  <= 4'd0;
      r_illegal     <= 1'b0;
      r_is_branch   <= 1'b0;
      r_funct3      <= 3'd0;
      r_rsp_result  <= 32'd0;
      r_rsp_flags   <= 4'd0;
      r_rsp_taken   <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        // an illegal request still walks the pipeline but feeds the ALU zeros
        r_alu_a      <= w_dec_illegal ? 32'd0 : w_dec_a;
        r_alu_b      <= w_dec_illegal ? 32'd0 : w_dec_b;
        r_alucontrol <= w_dec_illegal ? ALU_ADD : w_dec_ctrl;
        r_illegal    <= w_dec_illegal;
        r_is_branch  <= w_dec_branch;
        r_funct3     <= bus.funct3;
      end
      if (r_state == EXEC) begin
        r_rsp_result  <= r_illegal ? 32'd0 : bus.alu_result;
        r_rsp_flags   <= r_illegal ? 4'd0 : bus.alu_flags;
        r_rsp_taken   <= r_is_branch && !r_illegal && w_cond;
        r_rsp_illegal <= r_illegal;
      end
    end
  end

endmodule
